// File: rtl/tff_arb_pkg.sv
// Shared types and width helpers for the toggle-bank arbiter.
package tff_arb_pkg;

    // RUN: grants allowed; HOLD: freeze or clr currently asserted
    typedef enum logic {
        RUN  = 1'b0,
        HOLD = 1'b1
    } arb_state_e;

    // Width needed to index n items, never less than one bit
    function automatic int unsigned idx_w(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/tff_cell.sv
// One toggle flip-flop of the shared bank; clr wins over a toggle.
module tff_cell (
    input  logic clk,
    input  logic reset,
    input  logic t,
    input  logic clr,
    output logic q
);

    // Toggle state with synchronous reset and clear
    always_ff @(posedge clk) begin
        if (reset) begin
            q <= 1'b0;
        end else if (clr) begin
            q <= 1'b0;
        end else if (t) begin
            q <= ~q;
        end
    end

endmodule

// File: rtl/tff_toggle_arbiter.sv
// Round-robin arbiter granting one toggle per clock into a shared bank of T flip-flops.
// Optional per-requester saturating grant counters: define TFF_ARB_STAT_EN.
module tff_toggle_arbiter
    import tff_arb_pkg::*;
#(
    parameter  int unsigned NREQ   = 4,
    parameter  int unsigned WIDTH  = 8,
    parameter  int unsigned STAT_W = 8,
    localparam int unsigned IDXW   = idx_w(WIDTH)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NREQ-1:0]        req,
    input  logic [NREQ*IDXW-1:0]   idx,
    input  logic                   freeze,
    input  logic                   clr,
    output logic [NREQ-1:0]        gnt,
    output logic [WIDTH-1:0]       q,
`ifdef TFF_ARB_STAT_EN
    output logic                   busy,
    output logic [NREQ*STAT_W-1:0] gnt_cnt
`else
    output logic                   busy
`endif
);

    localparam int unsigned PTRW = idx_w(NREQ);
    localparam int unsigned IBW  = idx_w(NREQ * IDXW);

    arb_state_e       state;
    arb_state_e       state_next;
    logic [PTRW-1:0]  ptr;
    logic [PTRW-1:0]  ptr_next;
    logic [NREQ-1:0]  gnt_next;
    logic             busy_next;

    logic             found;
    logic [PTRW-1:0]  win;
    logic [NREQ-1:0]  win_onehot;
    logic [IBW-1:0]   ibase;
    logic [IDXW-1:0]  win_idx;
    logic             grant_en;
    int unsigned      cand;

    // Rotating search from ptr; first pending requester wins
    always_comb begin
        found = 1'b0;
        win   = '0;
        cand  = 0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            cand = 32'(ptr) + k;
            if (cand >= NREQ) begin
                cand = cand - NREQ;
            end
            if (!found && req[PTRW'(cand)]) begin
                found = 1'b1;
                win   = PTRW'(cand);
            end
        end
    end

    assign win_onehot = found ? (NREQ'(1) << win) : '0;
    assign ibase      = IBW'(win) * IBW'(IDXW);
    assign win_idx    = idx[ibase +: IDXW];
    assign grant_en   = found & ~freeze & ~clr;

    // Bank of toggle cells; an out-of-range index matches no cell
    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        tff_cell u_cell (
            .clk   (clk),
            .reset (reset),
            .t     (grant_en && (win_idx == IDXW'(i))),
            .clr   (clr),
            .q     (q[i])
        );
    end

    // Next-state and next-output logic; clr dominates freeze dominates grant
    always_comb begin
        state_next = state;
        gnt_next   = '0;
        busy_next  = 1'b0;
        ptr_next   = ptr;

        case (state)
            RUN:     if (clr || freeze) state_next = HOLD;
            HOLD:    if (!clr && !freeze) state_next = RUN;
            default: state_next = RUN;
        endcase

        if (clr) begin
            busy_next = 1'b0;
        end else if (freeze) begin
            busy_next = |req;
        end else begin
            gnt_next  = win_onehot;
            busy_next = |(req & ~win_onehot);
            if (found) begin
                ptr_next = (win == PTRW'(NREQ - 1)) ? '0 : PTRW'(win + 1'b1);
            end
        end
    end

    // State, pointer and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= RUN;
            ptr   <= '0;
            gnt   <= '0;
            busy  <= 1'b0;
        end else begin
            state <= state_next;
            ptr   <= ptr_next;
            gnt   <= gnt_next;
            busy  <= busy_next;
        end
    end

`ifdef TFF_ARB_STAT_EN
    logic [STAT_W-1:0] cnt [NREQ];

    // Saturating grant counters, cleared only by reset
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned r = 0; r < NREQ; r++) begin
                cnt[r] <= '0;
            end
        end else begin
            for (int unsigned r = 0; r < NREQ; r++) begin
                if (gnt_next[r] && (cnt[r] != '1)) begin
                    cnt[r] <= cnt[r] + 1'b1;
                end
            end
        end
    end

    for (genvar r = 0; r < NREQ; r++) begin : g_cnt
        assign gnt_cnt[r*STAT_W +: STAT_W] = cnt[r];
    end
`endif

endmodule

// File: tb/tb_tff_toggle_arbiter.sv
// Self-checking bench for tff_toggle_arbiter (scoreboard of expected gnt/q/busy per edge).
module tb_tff_toggle_arbiter;

    typedef struct packed {
        logic [3:0]  req;
        logic [11:0] idx;
        logic        frz;
        logic        clr;
    } stim_t;

    typedef struct packed {
        logic [3:0] gnt;
        logic [7:0] q;
        logic       busy;
    } exp_t;

    localparam logic [11:0] IDX_STD  = {3'd3, 3'd2, 3'd1, 3'd0};
    localparam logic [11:0] IDX_I0_3 = {3'd0, 3'd0, 3'd0, 3'd3};
    localparam logic [11:0] IDX_I1_3 = {3'd3, 3'd2, 3'd3, 3'd0};

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req;
    logic [11:0] idx;
    logic        freeze;
    logic        clr;
    logic [3:0]  gnt;
    logic [7:0]  q;
    logic        busy;

    logic [1:0]  req2;
    logic [5:0]  idx2;
    logic [1:0]  gnt2;
    logic [5:0]  q2;
    logic        busy2;

`ifdef TFF_ARB_STAT_EN
    logic [7:0]  gnt_cnt;
    logic [3:0]  gnt_cnt2;
`endif

    int checks   = 0;
    int failures = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    tff_toggle_arbiter #(.NREQ(4), .WIDTH(8), .STAT_W(2)) u_dut (
        .clk     (clk),
        .reset   (reset),
        .req     (req),
        .idx     (idx),
        .freeze  (freeze),
        .clr     (clr),
        .gnt     (gnt),
        .q       (q),
`ifdef TFF_ARB_STAT_EN
        .busy    (busy),
        .gnt_cnt (gnt_cnt)
`else
        .busy    (busy)
`endif
    );

    tff_toggle_arbiter #(.NREQ(2), .WIDTH(6), .STAT_W(2)) u_oor (
        .clk     (clk),
        .reset   (reset),
        .req     (req2),
        .idx     (idx2),
        .freeze  (1'b0),
        .clr     (1'b0),
        .gnt     (gnt2),
        .q       (q2),
`ifdef TFF_ARB_STAT_EN
        .busy    (busy2),
        .gnt_cnt (gnt_cnt2)
`else
        .busy    (busy2)
`endif
    );

    task automatic test_reset();
        exp_t e;
        reset = 1'b1; req = 4'b1111; idx = IDX_STD; freeze = 1'b0; clr = 1'b0;
        req2 = 2'b11; idx2 = '0;
        sb.push_back('{gnt: 4'b0000, q: 8'h00, busy: 1'b0});
        repeat (2) @(posedge clk);
        #1;
        e = sb.pop_front();
        checks++; if (gnt !== e.gnt) begin failures++; $display("FAIL reset_gnt got=%b want=%b", gnt, e.gnt); end
        checks++; if (q !== e.q) begin failures++; $display("FAIL reset_q got=%h want=%h", q, e.q); end
        checks++; if (busy !== e.busy) begin failures++; $display("FAIL reset_busy got=%b want=%b", busy, e.busy); end
        checks++; if (gnt2 !== 2'b00 || q2 !== 6'h00) begin failures++; $display("FAIL reset_oor got=%b/%h want=00/00", gnt2, q2); end
`ifdef TFF_ARB_STAT_EN
        checks++; if (gnt_cnt !== 8'h00) begin failures++; $display("FAIL reset_cnt got=%h want=00", gnt_cnt); end
`endif
        reset = 1'b0; req = 4'b0000; req2 = 2'b00;
    endtask

    task automatic test_single();
        stim_t st [4];
        exp_t  ex [4];
        exp_t  e;
        st = '{'{4'b0001, IDX_I0_3, 1'b0, 1'b0}, '{4'b0000, IDX_I0_3, 1'b0, 1'b0},
               '{4'b0001, IDX_I0_3, 1'b0, 1'b0}, '{4'b0000, IDX_I0_3, 1'b0, 1'b0}};
        ex = '{'{4'b0001, 8'h08, 1'b0}, '{4'b0000, 8'h08, 1'b0},
               '{4'b0001, 8'h00, 1'b0}, '{4'b0000, 8'h00, 1'b0}};
        foreach (st[i]) begin
            req = st[i].req; idx = st[i].idx; freeze = st[i].frz; clr = st[i].clr;
            sb.push_back(ex[i]);
            @(posedge clk);
            #1;
            e = sb.pop_front();
            checks++; if (gnt !== e.gnt) begin failures++; $display("FAIL single[%0d]_gnt got=%b want=%b", i, gnt, e.gnt); end
            checks++; if (q !== e.q) begin failures++; $display("FAIL single[%0d]_q got=%h want=%h", i, q, e.q); end
            checks++; if (busy !== e.busy) begin failures++; $display("FAIL single[%0d]_busy got=%b want=%b", i, busy, e.busy); end
        end
    endtask

    task automatic test_round_robin();
        stim_t st [6];
        exp_t  ex [6];
        exp_t  e;
        test_reset();
        st = '{'{4'b1111, IDX_STD, 1'b0, 1'b0}, '{4'b1111, IDX_STD, 1'b0, 1'b0},
               '{4'b1111, IDX_STD, 1'b0, 1'b0}, '{4'b1111, IDX_STD, 1'b0, 1'b0},
               '{4'b1111, IDX_STD, 1'b0, 1'b0}, '{4'b0000, IDX_STD, 1'b0, 1'b0}};
        ex = '{'{4'b0001, 8'h01, 1'b1}, '{4'b0010, 8'h03, 1'b1},
               '{4'b0100, 8'h07, 1'b1}, '{4'b1000, 8'h0F, 1'b1},
               '{4'b0001, 8'h0E, 1'b1}, '{4'b0000, 8'h0E, 1'b0}};
        foreach (st[i]) begin
            req = st[i].req; idx = st[i].idx; freeze = st[i].frz; clr = st[i].clr;
            sb.push_back(ex[i]);
            @(posedge clk);
            #1;
            e = sb.pop_front();
            checks++; if (gnt !== e.gnt) begin failures++; $display("FAIL rr[%0d]_gnt got=%b want=%b", i, gnt, e.gnt); end
            checks++; if (q !== e.q) begin failures++; $display("FAIL rr[%0d]_q got=%h want=%h", i, q, e.q); end
            checks++; if (busy !== e.busy) begin failures++; $display("FAIL rr[%0d]_busy got=%b want=%b", i, busy, e.busy); end
        end
    endtask

    task automatic test_collision_wrap();
        stim_t st [6];
        exp_t  ex [6];
        exp_t  e;
        test_reset();
        // grant req2 alone to park ptr at 3, then collide 0 and 3
        st = '{'{4'b0100, IDX_STD, 1'b0, 1'b0}, '{4'b1001, IDX_STD, 1'b0, 1'b0},
               '{4'b0001, IDX_STD, 1'b0, 1'b0}, '{4'b0011, IDX_STD, 1'b0, 1'b0},
               '{4'b0001, IDX_STD, 1'b0, 1'b0}, '{4'b0000, IDX_STD, 1'b0, 1'b0}};
        ex = '{'{4'b0100, 8'h04, 1'b0}, '{4'b1000, 8'h0C, 1'b1},
               '{4'b0001, 8'h0D, 1'b0}, '{4'b0010, 8'h0F, 1'b1},
               '{4'b0001, 8'h0E, 1'b0}, '{4'b0000, 8'h0E, 1'b0}};
        foreach (st[i]) begin
            req = st[i].req; idx = st[i].idx; freeze = st[i].frz; clr = st[i].clr;
            sb.push_back(ex[i]);
            @(posedge clk);
            #1;
            e = sb.pop_front();
            checks++; if (gnt !== e.gnt) begin failures++; $display("FAIL wrap[%0d]_gnt got=%b want=%b", i, gnt, e.gnt); end
            checks++; if (q !== e.q) begin failures++; $display("FAIL wrap[%0d]_q got=%h want=%h", i, q, e.q); end
            checks++; if (busy !== e.busy) begin failures++; $display("FAIL wrap[%0d]_busy got=%b want=%b", i, busy, e.busy); end
        end
    endtask

    task automatic test_freeze_clr();
        stim_t st [11];
        exp_t  ex [11];
        exp_t  e;
        test_reset();
        // build q=0F with ptr left at 2, then freeze, clear, and resume
        st = '{'{4'b0001, IDX_STD,  1'b0, 1'b0}, '{4'b0010, IDX_STD,  1'b0, 1'b0},
               '{4'b0100, IDX_STD,  1'b0, 1'b0}, '{4'b0010, IDX_I1_3, 1'b0, 1'b0},
               '{4'b0010, IDX_STD,  1'b1, 1'b0}, '{4'b0010, IDX_STD,  1'b1, 1'b0},
               '{4'b0010, IDX_STD,  1'b1, 1'b1}, '{4'b0010, IDX_STD,  1'b0, 1'b1},
               '{4'b0110, IDX_STD,  1'b0, 1'b0}, '{4'b0010, IDX_STD,  1'b0, 1'b0},
               '{4'b0000, IDX_STD,  1'b0, 1'b0}};
        ex = '{'{4'b0001, 8'h01, 1'b0}, '{4'b0010, 8'h03, 1'b0},
               '{4'b0100, 8'h07, 1'b0}, '{4'b0010, 8'h0F, 1'b0},
               '{4'b0000, 8'h0F, 1'b1}, '{4'b0000, 8'h0F, 1'b1},
               '{4'b0000, 8'h00, 1'b0}, '{4'b0000, 8'h00, 1'b0},
               '{4'b0100, 8'h04, 1'b1}, '{4'b0010, 8'h06, 1'b0},
               '{4'b0000, 8'h06, 1'b0}};
        foreach (st[i]) begin
            req = st[i].req; idx = st[i].idx; freeze = st[i].frz; clr = st[i].clr;
            sb.push_back(ex[i]);
            @(posedge clk);
            #1;
            e = sb.pop_front();
            checks++; if (gnt !== e.gnt) begin failures++; $display("FAIL frzclr[%0d]_gnt got=%b want=%b", i, gnt, e.gnt); end
            checks++; if (q !== e.q) begin failures++; $display("FAIL frzclr[%0d]_q got=%h want=%h", i, q, e.q); end
            checks++; if (busy !== e.busy) begin failures++; $display("FAIL frzclr[%0d]_busy got=%b want=%b", i, busy, e.busy); end
        end
        freeze = 1'b0; clr = 1'b0;
    endtask

    task automatic test_stat();
        exp_t e;
        test_reset();
        // req0 held: each cycle is a fresh grant toggling bit 0
        for (int i = 0; i < 6; i++) begin
            req = (i < 5) ? 4'b0001 : 4'b0000;
            idx = IDX_STD;
            sb.push_back('{gnt: (i < 5) ? 4'b0001 : 4'b0000,
                           q: (i % 2 == 0) ? 8'h01 : ((i < 5) ? 8'h00 : 8'h01),
                           busy: 1'b0});
            @(posedge clk);
            #1;
            e = sb.pop_front();
            checks++; if (gnt !== e.gnt) begin failures++; $display("FAIL stat[%0d]_gnt got=%b want=%b", i, gnt, e.gnt); end
            checks++; if (q !== e.q) begin failures++; $display("FAIL stat[%0d]_q got=%h want=%h", i, q, e.q); end
        end
`ifdef TFF_ARB_STAT_EN
        checks++; if (gnt_cnt !== 8'h03) begin failures++; $display("FAIL stat_cnt_sat got=%h want=03", gnt_cnt); end
        clr = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
        checks++; if (gnt_cnt !== 8'h03) begin failures++; $display("FAIL stat_cnt_clr got=%h want=03", gnt_cnt); end
`endif
    endtask

    task automatic test_out_of_range();
        logic [1:0] rq [4];
        logic [5:0] ix [4];
        exp_t       ex [4];
        exp_t       e;
        // WIDTH=6 bank: index 6 and 7 address no bit
        rq = '{2'b01, 2'b10, 2'b01, 2'b00};
        ix = '{{3'd0, 3'd7}, {3'd2, 3'd7}, {3'd0, 3'd6}, {3'd0, 3'd0}};
        ex = '{'{4'b0001, 8'h00, 1'b0}, '{4'b0010, 8'h04, 1'b0},
               '{4'b0001, 8'h04, 1'b0}, '{4'b0000, 8'h04, 1'b0}};
        foreach (rq[i]) begin
            req2 = rq[i]; idx2 = ix[i];
            sb.push_back(ex[i]);
            @(posedge clk);
            #1;
            e = sb.pop_front();
            checks++; if (gnt2 !== e.gnt[1:0]) begin failures++; $display("FAIL oor[%0d]_gnt got=%b want=%b", i, gnt2, e.gnt[1:0]); end
            checks++; if (q2 !== e.q[5:0]) begin failures++; $display("FAIL oor[%0d]_q got=%h want=%h", i, q2, e.q[5:0]); end
        end
    endtask

    initial begin
        reset = 1'b1; req = '0; idx = '0; freeze = 1'b0; clr = 1'b0; req2 = '0; idx2 = '0;
        @(posedge clk);
        #1;
        test_reset();
        test_single();
        test_round_robin();
        test_collision_wrap();
        test_freeze_clr();
        test_stat();
        test_out_of_range();
        checks++; if (sb.size() != 0) begin failures++; $display("FAIL scoreboard_left got=%0d want=0", sb.size()); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
